mdu_pipe: RTL and testbench
===========================

Name: mdu_pipe

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the E stage of the 5-stage MIPS pipeline.
- Accepts one mult/div operation per issue, counts down a configurable latency, then commits the result to HI/LO.
- Exposes `busy` so the hazard unit can stall dependent instructions in D.
- Provides a single read port (mfhi/mflo) with forwarding-free, register-based timing.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  issue strobe, valid for one cycle, from the E stage.
- op  in  3  operation code (see Behaviour).
- a  in  WIDTH  operand rs (forwarded value).
- b  in  WIDTH  operand rt (forwarded value).
- busy  out  1  multi-cycle operation in flight.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- rd_data  out  WIDTH  read result: hi if op==MFHI, lo if op==MFLO, else 0; combinational from op.

Behaviour:
- op encoding: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
- reset low, asynchronously: busy=0, hi=0, lo=0, counter=0, shadow regs=0, and any in-flight op is discarded.
- States: IDLE, RUN.
- IDLE with start and op in {MULT, MULTU, DIV, DIVU}:
  - Result is computed from a/b and latched into shadow_hi/shadow_lo.
  - counter is loaded with MULT_CYCLES-1 or DIV_CYCLES-1; go to RUN.
  - busy is 1 from the next cycle.
- RUN: counter decrements each cycle. On the edge where counter==0, hi/lo take the shadow values, busy goes 0 and the state returns to IDLE.
- Latency: start sampled at edge t → busy high for exactly N cycles → new hi/lo visible the same cycle busy is first 0.
- MTHI/MTLO with start in IDLE: hi (or lo) = a at the next edge; busy stays 0.
- start while busy=1 (any op) is ignored and state is unchanged. The hazard unit guarantees this never happens; an assertion flags it.
- MFHI/MFLO need no start; rd_data reflects committed hi/lo only. Reading during RUN returns the old value; the stall unit prevents this.
- MULT: signed 2*WIDTH product; hi = upper half, lo = lower half. MULTU: unsigned.
- DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Most-negative / -1 gives lo = most-negative, hi = 0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (b==0): hi/lo are left unchanged at commit. busy still runs DIV_CYCLES cycles.
- op values outside MULT..MTLO together with start are no-ops.

Optional Feature:
- MDU_MADD_EN defined:
  - op is widened to 4 bits; adds 8 MADD, 9 MADDU, 10 MSUB, 11 MSUBU.
  - {hi,lo} ± product (signed or unsigned) is computed at commit using the {hi,lo} value current at commit.
  - Latency is MULT_CYCLES.
- MDU_MADD_EN undefined: op is 3 bits and these codes do not exist.

Decomposition:
- Package mdu_pkg:
  - op encodings (OP_MULT..OP_MFLO and the optional OP_MADD..OP_MSUBU);
  - state encodings S_IDLE, S_RUN;
  - function is_md_op(op) used by the hazard unit.
- One combinational sub-module, mdu_calc(WIDTH):
  - inputs a, b, op;
  - outputs res_hi, res_lo, div_zero.
- mdu_pipe holds the FSM, counter, shadow regs and HI/LO.

Test Plan:
- MULT a=32'hFFFF_FFFE (-2), b=3, MULT_CYCLES=5 → busy high 5 cycles; then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA.
- DIV a=-7, b=2 → after 10 busy cycles lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1). DIVU with the same operands → lo=32'h7FFF_FFFC, hi=1.
- MTHI a=32'h1234_5678, then MFHI next cycle → rd_data=32'h1234_5678 with busy never asserted. Then DIV b=0 → hi/lo unchanged after busy drops.
- MULTU a=b=32'hFFFF_FFFF, then a second start at busy cycle 2 → second op ignored; final hi=32'hFFFF_FFFE, lo=1.
- DIV started, then reset pulsed low mid-RUN → busy=0, hi=lo=0 immediately; no commit after reset is released.
- (MDU_MADD_EN) hi=0, lo=10, MADD a=3, b=4 → after 5 cycles lo=22, hi=0. MSUBU a=1, b=30 → hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF8.

Source files
------------

// File: rtl/mdu_pkg.sv
// Opcodes, FSM encodings and decode helpers shared by mdu_pipe and the hazard unit.
// Define MDU_MADD_EN to widen op to 4 bits and add the MADD/MADDU/MSUB/MSUBU opcodes.
package mdu_pkg;

`ifdef MDU_MADD_EN
  localparam int OP_W = 4;
`else
  localparam int OP_W = 3;
`endif

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_MULT  = op_t'(0);
  localparam op_t OP_MULTU = op_t'(1);
  localparam op_t OP_DIV   = op_t'(2);
  localparam op_t OP_DIVU  = op_t'(3);
  localparam op_t OP_MTHI  = op_t'(4);
  localparam op_t OP_MTLO  = op_t'(5);
  localparam op_t OP_MFHI  = op_t'(6);
  localparam op_t OP_MFLO  = op_t'(7);
`ifdef MDU_MADD_EN
  localparam op_t OP_MADD  = op_t'(8);
  localparam op_t OP_MADDU = op_t'(9);
  localparam op_t OP_MSUB  = op_t'(10);
  localparam op_t OP_MSUBU = op_t'(11);
`endif

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  function automatic logic is_div_op(input op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

`ifdef MDU_MADD_EN
  function automatic logic is_acc_op(input op_t op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction
`endif

  // True for every opcode that occupies the unit for a multi-cycle run.
  function automatic logic is_md_op(input op_t op);
    logic md;
    md = (op == OP_MULT) || (op == OP_MULTU) || is_div_op(op);
`ifdef MDU_MADD_EN
    md = md || is_acc_op(op);
`endif
    return md;
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath: produces the HI/LO pair for one operation.
// Under MDU_MADD_EN the accumulate opcodes return the bare product; the top adds it at commit.
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  logic signed [2*WIDTH-1:0] a_ext, b_ext, prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic signed [WIDTH-1:0]   a_s, dvs_s, quo_s, rem_s;
  logic        [WIDTH-1:0]   dvs_u, quo_u, rem_u;
  logic                      b_zero, ovf;

  assign a_ext  = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_ext  = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_s = a_ext * b_ext;
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign b_zero = (b == '0);
  assign ovf    = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

  // Most-negative / -1 is divided by 1 instead, which yields exactly the
  // required (most-negative, 0) pair without overflowing the divider.
  always_comb begin
    a_s   = a;
    dvs_s = (b_zero || ovf) ? WIDTH'(1) : b;
    dvs_u = b_zero ? WIDTH'(1) : b;
    quo_s = a_s / dvs_s;
    rem_s = a_s % dvs_s;
    quo_u = a / dvs_u;
    rem_u = a % dvs_u;
  end

  always_comb begin
    res_hi   = '0;
    res_lo   = '0;
    div_zero = 1'b0;
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        res_lo   = quo_s;
        res_hi   = rem_s;
        div_zero = b_zero;
      end
      OP_DIVU: begin
        res_lo   = quo_u;
        res_hi   = rem_u;
        div_zero = b_zero;
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MSUB:   {res_hi, res_lo} = prod_s;
      OP_MADDU, OP_MSUBU: {res_hi, res_lo} = prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_pipe.sv
// E-stage multi-cycle multiply/divide unit with HI/LO registers and a busy flag for the hazard unit.
// Define MDU_MADD_EN to enable multiply-accumulate/subtract into {HI,LO} at commit.
module mdu_pipe
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             div_zero;
`ifdef MDU_MADD_EN
  logic             acc_q, acc_d, sub_q, sub_d;
  logic [2*WIDTH-1:0] hilo, shadow;

  assign hilo   = {hi_q, lo_q};
  assign shadow = {sh_hi_q, sh_lo_q};
`endif

  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .a        (a),
    .b        (b),
    .op       (op),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_MADD_EN
    acc_d   = acc_q;
    sub_d   = sub_q;
`endif
    if (state_q == S_IDLE) begin
      if (start) begin
        if (is_md_op(op)) begin
          sh_hi_d = res_hi;
          sh_lo_d = res_lo;
          dz_d    = div_zero;
          cnt_d   = is_div_op(op) ? DIV_LOAD : MULT_LOAD;
          state_d = S_RUN;
`ifdef MDU_MADD_EN
          acc_d   = is_acc_op(op);
          sub_d   = (op == OP_MSUB) || (op == OP_MSUBU);
`endif
        end else if (op == OP_MTHI) begin
          hi_d = a;
        end else if (op == OP_MTLO) begin
          lo_d = a;
        end
      end
    end else if (cnt_q == '0) begin
      // Commit; a divide by zero leaves HI/LO untouched.
      state_d = S_IDLE;
      if (!dz_q) begin
        hi_d = sh_hi_q;
        lo_d = sh_lo_q;
`ifdef MDU_MADD_EN
        if (acc_q) begin
          {hi_d, lo_d} = sub_q ? (hilo - shadow) : (hilo + shadow);
        end
`endif
      end
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MDU_MADD_EN
      acc_q   <= 1'b0;
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MDU_MADD_EN
      acc_q   <= acc_d;
      sub_q   <= sub_d;
`endif
    end
  end

  assign busy    = (state_q == S_RUN);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = (op == OP_MFHI) ? hi_q : (op == OP_MFLO) ? lo_q : '0;

`ifndef SYNTHESIS
  // The hazard unit must never issue while busy; such a start is dropped.
  start_while_busy: assert property (@(posedge clk) disable iff (!reset) !(start && busy))
    else $warning("mdu_pipe: start ignored while busy");
`endif

endmodule

// File: tb/tb_mdu_pipe.sv
// Self-checking bench for mdu_pipe: directed vector table, hand-written corner sequences
// and randomized operations checked against an arithmetic reference model.
module tb_mdu_pipe;
  import mdu_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  op_t          op = OP_MULT;
  logic [W-1:0] a = '0, b = '0;
  logic         busy;
  logic [W-1:0] hi, lo, rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_hi, m_lo;

  typedef struct {
    op_t          op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           n;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t tbl[$];

  mdu_pipe #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input op_t o, input logic [W-1:0] va, input logic [W-1:0] vb,
                              input int n, input logic [W-1:0] eh, input logic [W-1:0] el);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.n = n; v.hi = eh; v.lo = el;
    return v;
  endfunction

  // Reference model: plain 64-bit arithmetic on the architectural HI/LO pair.
  task automatic model(input op_t o, input logic [W-1:0] va, input logic [W-1:0] vb, output int n);
    longint            sa, sb;
    longint unsigned   ua, ub;
    logic [2*W-1:0]    t, acc;
    sa = longint'($signed(va));
    sb = longint'($signed(vb));
    ua = {32'd0, va};
    ub = {32'd0, vb};
    n  = 0;
    acc = {m_hi, m_lo};
    case (o)
      OP_MULT:  begin n = MC; t = sa * sb; {m_hi, m_lo} = t; end
      OP_MULTU: begin n = MC; t = ua * ub; {m_hi, m_lo} = t; end
      OP_DIV: begin
        n = DC;
        if (vb != 0) begin
          t = sa / sb; m_lo = t[W-1:0];
          t = sa % sb; m_hi = t[W-1:0];
        end
      end
      OP_DIVU: begin
        n = DC;
        if (vb != 0) begin
          t = ua / ub; m_lo = t[W-1:0];
          t = ua % ub; m_hi = t[W-1:0];
        end
      end
      OP_MTHI: m_hi = va;
      OP_MTLO: m_lo = va;
`ifdef MDU_MADD_EN
      OP_MADD:  begin n = MC; t = sa * sb; {m_hi, m_lo} = acc + t; end
      OP_MADDU: begin n = MC; t = ua * ub; {m_hi, m_lo} = acc + t; end
      OP_MSUB:  begin n = MC; t = sa * sb; {m_hi, m_lo} = acc - t; end
      OP_MSUBU: begin n = MC; t = ua * ub; {m_hi, m_lo} = acc - t; end
`endif
      default: ;
    endcase
  endtask

  task automatic run_op(input op_t o, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input int exp_n, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input string nm);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(negedge clk);
    start = 1'b0; op = OP_MULT;
    n = 0;
    while (busy && n < 64) begin
      n++;
      @(negedge clk);
    end
    chk({nm, " busy_cycles"}, W'(n), W'(exp_n));
    chk({nm, " hi"}, hi, eh);
    chk({nm, " lo"}, lo, el);
    op = OP_MFHI; #1;
    chk({nm, " rd_mfhi"}, rd_data, eh);
    op = OP_MFLO; #1;
    chk({nm, " rd_mflo"}, rd_data, el);
    op = OP_MULT;
  endtask

  initial begin
    int n;
    op_t ro;
    logic [W-1:0] ra, rb;

    tbl.push_back(mk(OP_MULT,  32'hFFFF_FFFE, 32'd3,        MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA));
    tbl.push_back(mk(OP_DIV,   32'hFFFF_FFF9, 32'd2,        DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD));
    tbl.push_back(mk(OP_DIVU,  32'hFFFF_FFF9, 32'd2,        DC, 32'h0000_0001, 32'h7FFF_FFFC));
    tbl.push_back(mk(OP_MTHI,  32'h1234_5678, 32'd0,        0,  32'h1234_5678, 32'h7FFF_FFFC));
    tbl.push_back(mk(OP_DIV,   32'd5,         32'd0,        DC, 32'h1234_5678, 32'h7FFF_FFFC));
    tbl.push_back(mk(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, DC, 32'h0000_0000, 32'h8000_0000));
    tbl.push_back(mk(OP_MTLO,  32'hCAFE_F00D, 32'd0,        0,  32'h0000_0000, 32'hCAFE_F00D));
    tbl.push_back(mk(OP_MFHI,  32'h5555_5555, 32'd7,        0,  32'h0000_0000, 32'hCAFE_F00D));
    tbl.push_back(mk(OP_DIV,   32'd7,         32'hFFFF_FFFE, DC, 32'h0000_0001, 32'hFFFF_FFFD));
    tbl.push_back(mk(OP_MULT,  32'h8000_0000, 32'h8000_0000, MC, 32'h4000_0000, 32'h0000_0000));
`ifdef MDU_MADD_EN
    tbl.push_back(mk(OP_MTHI,  32'd0,         32'd0,        0,  32'h0000_0000, 32'h0000_0000));
    tbl.push_back(mk(OP_MTLO,  32'd10,        32'd0,        0,  32'h0000_0000, 32'd10));
    tbl.push_back(mk(OP_MADD,  32'd3,         32'd4,        MC, 32'h0000_0000, 32'd22));
    tbl.push_back(mk(OP_MSUBU, 32'd1,         32'd30,       MC, 32'hFFFF_FFFF, 32'hFFFF_FFF8));
    tbl.push_back(mk(OP_MSUB,  32'hFFFF_FFFF, 32'd2,        MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA));
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    op = OP_MFHI; #1;
    chk("reset rd_mfhi", rd_data, 32'd0);
    op = OP_MULT; #1;
    chk("rd_non_mf_zero", rd_data, 32'd0);

    foreach (tbl[i])
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].n, tbl[i].hi, tbl[i].lo, $sformatf("vec%0d", i));

    // Second start in the middle of a run must be dropped.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 64) begin
      n++;
      if (n == 2) begin
        start = 1'b1; op = OP_MTHI; a = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0; op = OP_MULT;
      end
      @(negedge clk);
    end
    start = 1'b0; op = OP_MULT;
    chk("overlap busy_cycles", W'(n), W'(MC));
    chk("overlap hi", hi, 32'hFFFF_FFFE);
    chk("overlap lo", lo, 32'h0000_0001);
    @(negedge clk);
    chk("overlap busy_after", {31'd0, busy}, 32'd0);
    chk("overlap hi_after", hi, 32'hFFFF_FFFE);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; op = OP_MULT;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset hi", hi, 32'd0);
    chk("midreset lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    repeat (DC + 4) begin
      @(negedge clk);
      if (busy || hi != 0 || lo != 0) n++;
    end
    chk("postreset no_commit", W'(n), 32'd0);

    // Randomized operations against the reference model.
    m_hi = '0;
    m_lo = '0;
    for (int k = 0; k < 60; k++) begin
`ifdef MDU_MADD_EN
      ro = op_t'($urandom_range(0, 15));
`else
      ro = op_t'($urandom_range(0, 7));
`endif
      case ($urandom_range(0, 7))
        0: ra = 32'd0;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      model(ro, ra, rb, n);
      run_op(ro, ra, rb, n, m_hi, m_lo, $sformatf("rand%0d op%0d", k, ro));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
